// File: rtl/mem_addr_sel_reg.sv
// ----------------------------------------------------------------------------
// mem_addr_sel_reg
//
// Registered memory-address source selector with a req/ack memory handshake.
// Sits between the control unit and the memory port of a multicycle datapath.
//
// On start (in IDLE) the block picks one of N_SRC external address sources or
// one of N_VEC fixed exception vectors, latches the chosen address into
// mem_addr and raises mem_req until memory acknowledges. Bad selects and
// request timeouts are reported with a one-cycle err pulse plus a sticky
// err_code.
//
// Optional feature (compile-time macro):
//   MEM_ADDR_ALIGN_CHK_EN  when defined, half/word accesses on misaligned
//                          addresses are rejected with err_code = 2'b10 and
//                          no memory request is made. When undefined, no
//                          alignment check is done and the address is passed
//                          unchanged.
//
// Parameters:
//   WIDTH    address width
//   N_SRC    number of external address sources
//   N_VEC    number of fixed vectors; vector k = VEC_BASE + k
//   VEC_BASE value of the first exception vector
//   SEL_W    select width; N_SRC + N_VEC must be <= 2**SEL_W
//   TIMEOUT  max cycles spent in REQ before the access is aborted (>= 2)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   start     in   request an access using the current sel/size
//   sel       in   source select
//   size      in   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   src_in    in   source k at [k*WIDTH +: WIDTH]
//   mem_ack   in   memory accepted the request
//   mem_addr  out  registered address, stable while mem_req = 1
//   mem_req   out  access request to memory
//   busy      out  FSM not IDLE
//   done      out  one-cycle pulse: access completed
//   err       out  one-cycle pulse: access aborted
//   err_code  out  01 bad sel, 10 misaligned, 11 timeout; holds until next start
// ----------------------------------------------------------------------------
module mem_addr_sel_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SRC    = 5,
    parameter int unsigned N_VEC    = 3,
    parameter int unsigned VEC_BASE = 253,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [SEL_W-1:0]       sel,
    input  logic [1:0]             size,
    input  logic [N_SRC*WIDTH-1:0] src_in,
    input  logic                   mem_ack,
    output logic [WIDTH-1:0]       mem_addr,
    output logic                   mem_req,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Counter wide enough to hold TIMEOUT-1 for any legal TIMEOUT.
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_SEL  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

`ifdef MEM_ADDR_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFin
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e           state;
    logic [CNT_W-1:0] req_cnt;

    // ------------------------------------------------------------------------
    // Select decode
    // ------------------------------------------------------------------------
    logic [31:0]      sel_idx;
    logic             sel_is_src;
    logic             sel_is_vec;
    logic             sel_bad;
    logic [WIDTH-1:0] src_addr;
    logic [WIDTH-1:0] vec_addr;
    logic [WIDTH-1:0] next_addr;
    logic             size_half;
    logic             size_word;
    logic             misaligned;

    always_comb begin
        sel_idx    = 32'(sel);
        sel_is_src = (sel_idx < N_SRC);
        sel_is_vec = !sel_is_src && (sel_idx < (N_SRC + N_VEC));
        sel_bad    = !sel_is_src && !sel_is_vec;
    end

    // Loop-based mux keeps the slice index in range even for illegal selects.
    always_comb begin
        src_addr = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (sel_idx == k) begin
                src_addr = src_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Only meaningful when sel_is_vec; the wrapped value otherwise is masked below.
    always_comb begin
        vec_addr = WIDTH'(VEC_BASE) + WIDTH'(sel_idx - N_SRC);
    end

    always_comb begin
        if (sel_is_src) begin
            next_addr = src_addr;
        end else if (sel_is_vec) begin
            next_addr = vec_addr;
        end else begin
            next_addr = '0;
        end
    end

    // Size 11 is reserved and handled as a word access.
    always_comb begin
        size_half  = (size == 2'b01);
        size_word  = size[1];
        misaligned = ALIGN_CHK &&
                     ((size_half && next_addr[0]) ||
                      (size_word && (next_addr[1:0] != 2'b00)));
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            // Drops an in-flight request immediately; any pending ack is lost.
            state    <= StIdle;
            req_cnt  <= '0;
            mem_addr <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                StIdle: begin
                    if (start) begin
                        req_cnt <= '0;
                        busy    <= 1'b1;
                        if (sel_bad) begin
                            mem_addr <= '0;
                            err_code <= ERR_BAD_SEL;
                            err      <= 1'b1;
                            state    <= StFin;
                        end else if (misaligned) begin
                            mem_addr <= next_addr;
                            err_code <= ERR_MISALIGN;
                            err      <= 1'b1;
                            state    <= StFin;
                        end else begin
                            mem_addr <= next_addr;
                            err_code <= ERR_NONE;
                            mem_req  <= 1'b1;
                            state    <= StReq;
                        end
                    end
                end

                StReq: begin
                    // Ack is checked first so an ack in the last allowed cycle
                    // still completes the access.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        state   <= StFin;
                    end else if (req_cnt == CNT_LAST) begin
                        mem_req  <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= StFin;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end

                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end

                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_addr_sel_reg.sv
module tb_mem_addr_sel_reg;

    localparam int WIDTH    = 32;
    localparam int N_SRC    = 5;
    localparam int N_VEC    = 3;
    localparam int VEC_BASE = 253;
    localparam int SEL_W    = 4;
    localparam int TIMEOUT  = 16;

`ifdef MEM_ADDR_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [SEL_W-1:0]       sel;
    logic [1:0]             size;
    logic [N_SRC*WIDTH-1:0] src_in;
    logic                   mem_ack;
    logic [WIDTH-1:0]       mem_addr;
    logic                   mem_req;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;

    logic [WIDTH-1:0] src_arr [N_SRC];

    int checks   = 0;
    int failures = 0;

    always_comb begin
        src_in = '0;
        for (int k = 0; k < N_SRC; k++) src_in[k*WIDTH +: WIDTH] = src_arr[k];
    end

    mem_addr_sel_reg #(
        .WIDTH   (WIDTH),
        .N_SRC   (N_SRC),
        .N_VEC   (N_VEC),
        .VEC_BASE(VEC_BASE),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sel     (sel),
        .size    (size),
        .src_in  (src_in),
        .mem_ack (mem_ack),
        .mem_addr(mem_addr),
        .mem_req (mem_req),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: which address a select should produce.
    function automatic logic [WIDTH-1:0] ref_addr(input int s);
        if (s < N_SRC) return src_arr[s];
        if (s < N_SRC + N_VEC) return WIDTH'(VEC_BASE + s - N_SRC);
        return '0;
    endfunction

    function automatic bit ref_misaligned(input int s, input logic [1:0] sz);
        logic [WIDTH-1:0] a;
        int               align;
        a     = ref_addr(s);
        align = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        return ALIGN && (s < N_SRC + N_VEC) && ((a % align) != 0);
    endfunction

    // One access from an IDLE cycle. ack_at is the cycle (start = cycle 0) in
    // which mem_ack is raised; values outside 1..TIMEOUT mean no ack in time.
    // noise adds ignored starts, acks outside REQ and source churn.
    task automatic do_access(input int s, input logic [1:0] sz, input int ack_at,
                             input bit noise, input string name);
        int               end_c;
        bit               bad;
        bit               mis;
        bit               ok;
        logic [1:0]       exp_code;
        logic [WIDTH-1:0] exp_addr;
        bit               in_req;

        bad      = (s >= N_SRC + N_VEC);
        mis      = !bad && ref_misaligned(s, sz);
        exp_addr = ref_addr(s);
        if (bad || mis) begin
            end_c = 1; ok = 1'b0; exp_code = bad ? 2'b01 : 2'b10;
        end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
            end_c = ack_at + 1; ok = 1'b1; exp_code = 2'b00;
        end else begin
            end_c = TIMEOUT + 1; ok = 1'b0; exp_code = 2'b11;
        end

        sel     = SEL_W'(s);
        size    = sz;
        start   = 1'b1;
        mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();

        for (int c = 1; c <= end_c; c++) begin
            in_req = (c < end_c);
            checks++;
            if (mem_req !== in_req) begin
                failures++;
                $display("FAIL %s c=%0d mem_req got=%b exp=%b", name, c, mem_req, in_req);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s c=%0d busy got=%b exp=1", name, c, busy);
            end
            checks++;
            if (done !== (c == end_c && ok)) begin
                failures++;
                $display("FAIL %s c=%0d done got=%b exp=%b", name, c, done, c == end_c && ok);
            end
            checks++;
            if (err !== (c == end_c && !ok)) begin
                failures++;
                $display("FAIL %s c=%0d err got=%b exp=%b", name, c, err, c == end_c && !ok);
            end
            checks++;
            if (mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL %s c=%0d mem_addr got=%h exp=%h", name, c, mem_addr, exp_addr);
            end
            checks++;
            if (err_code !== ((c == end_c) ? exp_code : 2'b00)) begin
                failures++;
                $display("FAIL %s c=%0d err_code got=%b exp=%b", name, c, err_code,
                         (c == end_c) ? exp_code : 2'b00);
            end

            start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_ack = (c == ack_at) || (noise && !in_req && ($urandom_range(0, 1) == 1));
            if (noise) begin
                sel = SEL_W'($urandom_range(0, 15));
                src_arr[$urandom_range(0, N_SRC - 1)] = $urandom();
            end
            tick();
        end

        // Back in IDLE: nothing pending, error code sticky.
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s idle busy/req/done/err got=%b%b%b%b exp=0000", name,
                     busy, mem_req, done, err);
        end
        checks++;
        if (err_code !== exp_code) begin
            failures++;
            $display("FAIL %s idle err_code got=%b exp=%b", name, err_code, exp_code);
        end
        start   = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; sel = '0; size = 2'b10; mem_ack = 1'b0;
        for (int k = 0; k < N_SRC; k++) src_arr[k] = WIDTH'(32'h100 * (k + 1));
        tick();
        tick();
        checks++;
        if (mem_addr !== '0 || mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset addr/req/busy got=%h/%b/%b exp=0/0/0", mem_addr, mem_req, busy);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL reset done/err/code got=%b/%b/%b exp=0/0/00", done, err, err_code);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_access();
        src_arr[1] = 32'h0000_2000;
        sel = SEL_W'(1); size = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid pre mem_req got=%b exp=1", mem_req);
        end
        reset = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== '0 || done !== 1'b0 ||
                err !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid cyc%0d req/busy/addr/done/err got=%b/%b/%h/%b/%b exp=0/0/0/0/0",
                         i, mem_req, busy, mem_addr, done, err);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("FAIL rst_after cyc%0d req/busy/done/err got=%b/%b/%b/%b exp=0/0/0/0",
                         i, mem_req, busy, done, err);
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_src_access();
        src_arr[1] = 32'h0000_1000;
        do_access(1, 2'b10, 3, 1'b0, "src1_word");
    endtask

    task automatic test_vectors();
        for (int s = N_SRC; s < N_SRC + N_VEC; s++) do_access(s, 2'b00, 1, 1'b0, "vector");
    endtask

    task automatic test_bad_sel();
        for (int s = N_SRC + N_VEC; s < 16; s++)
            do_access(s, 2'($urandom_range(0, 3)), $urandom_range(1, 4), 1'b1, "bad_sel");
    endtask

    task automatic test_timeout();
        do_access(2, 2'b00, 0, 1'b0, "timeout");
        do_access(2, 2'b00, TIMEOUT, 1'b0, "ack_last");
        do_access(3, 2'b00, TIMEOUT + 1, 1'b1, "ack_in_fin");
    endtask

    task automatic test_align();
        src_arr[0] = 32'h0000_1002;
        do_access(0, 2'b10, 2, 1'b0, "align_word");
        do_access(0, 2'b01, 2, 1'b0, "align_half");
        do_access(0, 2'b11, 1, 1'b0, "align_rsvd");
        src_arr[0] = 32'h0000_1003;
        do_access(0, 2'b01, 1, 1'b0, "align_half_odd");
        do_access(0, 2'b00, 1, 1'b0, "align_byte_odd");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_access(i, 2'b00, 1, 1'b0, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N_SRC; k++) src_arr[k] = $urandom();
            do_access($urandom_range(0, 15), 2'($urandom_range(0, 3)),
                      $urandom_range(0, TIMEOUT + 2), 1'b1, "random");
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_src_access();
        test_vectors();
        test_bad_sel();
        test_timeout();
        test_align();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
